// File: rtl/tx_byte_queue.sv
// Byte queue that serialises 1..WORD_BYTES-byte pushes, MSB first, onto a byte stream.
// Optional macro TXQ_DROP_ON_FULL_EN: drop bytes while full and flag overflow.
module tx_byte_queue #(
    parameter int unsigned DEPTH      = 512,
    parameter int unsigned WORD_BYTES = 4,
    parameter int unsigned LOG_DEPTH  = $clog2(DEPTH)
) (
    input  logic                              CLK,
    input  logic                              INITIALIZE,
    input  logic                              push_valid,
    output logic                              push_ready,
    input  logic [8*WORD_BYTES-1:0]           push_data,
    input  logic [$clog2(WORD_BYTES+1)-1:0]   push_len,
    output logic                              tx_valid,
    input  logic                              tx_ready,
    output logic [7:0]                        tx_data,
    output logic [LOG_DEPTH:0]                count,
    output logic                              empty,
    output logic                              full,
    output logic                              overflow
);

    localparam int unsigned LenW = $clog2(WORD_BYTES + 1);
    localparam int unsigned CntW = LOG_DEPTH + 1;
    localparam logic [LenW-1:0] MaxLen   = LenW'(WORD_BYTES);
    localparam logic [LenW-1:0] LenOne   = LenW'(1);
    localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);
    localparam logic [CntW-1:0] CntOne   = CntW'(1);
    localparam logic [LOG_DEPTH-1:0] PtrOne = LOG_DEPTH'(1);

    if ((DEPTH & (DEPTH - 1)) != 0 || DEPTH < 2 * WORD_BYTES) begin : gen_bad_depth
        $error("tx_byte_queue: DEPTH must be a power of two and at least 2*WORD_BYTES");
    end
    if ((WORD_BYTES & (WORD_BYTES - 1)) != 0 || WORD_BYTES < 1 || WORD_BYTES > 8)
    begin : gen_bad_word
        $error("tx_byte_queue: WORD_BYTES must be a power of two in 1..8");
    end

    typedef enum logic [0:0] {StIdle, StWrite} state_e;

    state_e                  state_q, state_d;
    logic [LOG_DEPTH-1:0]    wr_ptr_q, wr_ptr_d;
    logic [LOG_DEPTH-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]         count_q, count_d;
    logic [8*WORD_BYTES-1:0] stage_q, stage_d;
    logic [LenW-1:0]         rem_q, rem_d;
    logic [7:0]              mem_q [DEPTH];

    logic [LenW-1:0] len_c;
    logic [7:0]      first_byte;
    logic [7:0]      stage_byte;
    logic [7:0]      wr_byte;
    logic            produce;
    logic            wr_en;
    logic            pop;
    logic            full_c;
    logic            empty_c;
`ifdef TXQ_DROP_ON_FULL_EN
    logic            drop;
    logic            overflow_q;
`endif

    assign full_c  = (count_q == DepthCnt);
    assign empty_c = (count_q == '0);

    always_comb begin
        len_c = (push_len > MaxLen) ? MaxLen : push_len;
    end

    // Byte index L-1 of the incoming word and index rem-1 of the staged word go out next.
    always_comb begin
        first_byte = '0;
        stage_byte = '0;
        for (int unsigned i = 0; i < WORD_BYTES; i++) begin
            if (len_c == LenW'(i + 1)) begin
                first_byte = push_data[8*i +: 8];
            end
            if (rem_q == LenW'(i + 1)) begin
                stage_byte = stage_q[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        stage_d    = stage_q;
        rem_d      = rem_q;
        push_ready = 1'b0;
        produce    = 1'b0;
        wr_byte    = stage_byte;
        unique case (state_q)
            StIdle: begin
`ifdef TXQ_DROP_ON_FULL_EN
                push_ready = 1'b1;
`else
                push_ready = !full_c;
`endif
                if (push_valid && push_ready && (len_c != '0)) begin
                    produce = 1'b1;
                    wr_byte = first_byte;
                    stage_d = push_data;
                    rem_d   = len_c - LenOne;
                    if (len_c > LenOne) begin
                        state_d = StWrite;
                    end
                end
            end
            StWrite: begin
`ifdef TXQ_DROP_ON_FULL_EN
                produce = 1'b1;
`else
                produce = !full_c;
`endif
                if (produce) begin
                    rem_d = rem_q - LenOne;
                    if (rem_q == LenOne) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // A produced byte only lands in the array when there is room for it.
    assign wr_en = produce && !full_c;
    assign pop   = !empty_c && tx_ready;
`ifdef TXQ_DROP_ON_FULL_EN
    assign drop  = produce && full_c;
`endif

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PtrOne;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrOne;
        end
        unique case ({wr_en, pop})
            2'b10:   count_d = count_q + CntOne;
            2'b01:   count_d = count_q - CntOne;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLK or posedge INITIALIZE) begin
        if (INITIALIZE) begin
            state_q  <= StIdle;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            stage_q  <= '0;
            rem_q    <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            stage_q  <= stage_d;
            rem_q    <= rem_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_byte;
        end
    end

`ifdef TXQ_DROP_ON_FULL_EN
    always_ff @(posedge CLK or posedge INITIALIZE) begin
        if (INITIALIZE) begin
            overflow_q <= 1'b0;
        end else if (drop) begin
            overflow_q <= 1'b1;
        end
    end
    assign overflow = overflow_q;
`else
    assign overflow = 1'b0;
`endif

    assign tx_valid = !empty_c;
    assign tx_data  = mem_q[rd_ptr_q];
    assign count    = count_q;
    assign empty    = empty_c;
    assign full     = full_c;

endmodule

// File: tb/tb_tx_byte_queue.sv
// Directed self-checking bench for tx_byte_queue (DEPTH=512, WORD_BYTES=4).
module tb_tx_byte_queue;

    logic        CLK = 1'b0;
    logic        INITIALIZE;
    logic        push_valid;
    logic        push_ready;
    logic [31:0] push_data;
    logic [2:0]  push_len;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  tx_data;
    logic [9:0]  count;
    logic        empty;
    logic        full;
    logic        overflow;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    tx_byte_queue dut (
        .CLK        (CLK),
        .INITIALIZE (INITIALIZE),
        .push_valid (push_valid),
        .push_ready (push_ready),
        .push_data  (push_data),
        .push_len   (push_len),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_data    (tx_data),
        .count      (count),
        .empty      (empty),
        .full       (full),
        .overflow   (overflow)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset;
        INITIALIZE = 1'b1;
        #3;
        INITIALIZE = 1'b0;
        tick();
    endtask

    // Single-byte pushes of (start+i) with no consumer; queue must have room.
    task automatic fill(input int n, input int start);
        tx_ready = 1'b0;
        for (int i = 0; i < n; i++) begin
            push_valid = 1'b1;
            push_len   = 3'd1;
            push_data  = 32'(start + i);
            tick();
        end
        push_valid = 1'b0;
    endtask

    // Pop n bytes and compare each one against the front of exp_q.
    task automatic drain(input int n, input string tag);
        logic [7:0] e;
        for (int i = 0; i < n; i++) begin
            e = exp_q.pop_front();
            chk({tag, "_valid"}, 32'(tx_valid), 32'd1);
            chk({tag, "_data"}, 32'(tx_data), 32'(e));
            tx_ready = 1'b1;
            tick();
        end
        tx_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] seq4 [4];
        int next;
        int popped;
        int guard;
        logic acc;
        logic pop;

        INITIALIZE = 1'b1;
        push_valid = 1'b0;
        push_data  = '0;
        push_len   = '0;
        tx_ready   = 1'b0;
        #2;
        chk("rst_push_ready", 32'(push_ready), 32'd1);
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        #2;
        INITIALIZE = 1'b0;
        tick();

        // 4-byte word streamed straight through, MSB first
        seq4 = '{8'h41, 8'h42, 8'h43, 8'h44};
        push_valid = 1'b1;
        push_len   = 3'd4;
        push_data  = 32'h4142_4344;
        tx_ready   = 1'b1;
        tick();
        push_valid = 1'b0;
        chk("w4_push_ready_busy", 32'(push_ready), 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk("w4_valid", 32'(tx_valid), 32'd1);
            chk("w4_data", 32'(tx_data), 32'(seq4[i]));
            chk("w4_count", 32'(count), 32'd1);
            if (i == 3) chk("w4_ready_back", 32'(push_ready), 32'd1);
            tick();
        end
        tx_ready = 1'b0;
        chk("w4_count_end", 32'(count), 32'd0);
        chk("w4_empty_end", 32'(empty), 32'd1);

        // 600 single-byte pushes against a stalled consumer
        next = 0;
        for (int c = 0; c < 600; c++) begin
            push_valid = 1'b1;
            push_len   = 3'd1;
            push_data  = 32'(next);
            acc = push_ready;
            tick();
            if (acc) next++;
        end
        chk("bb_accepted", 32'(next), 32'd512);
        chk("bb_full", 32'(full), 32'd1);
        chk("bb_push_ready", 32'(push_ready), 32'd0);
        chk("bb_count", 32'(count), 32'd512);
        chk("bb_overflow", 32'(overflow), 32'd0);

        popped = 0;
        guard  = 0;
        tx_ready = 1'b1;
        while (popped < 600 && guard < 2000) begin
            push_valid = (next < 600);
            push_data  = 32'(next);
            acc = push_valid && push_ready;
            pop = tx_valid;
            if (pop) chk("bb_drain_data", 32'(tx_data), 32'(popped & 8'hff));
            tick();
            if (acc) next++;
            if (pop) popped++;
            guard++;
        end
        push_valid = 1'b0;
        tx_ready   = 1'b0;
        chk("bb_drain_total", 32'(popped), 32'd600);
        chk("bb_drain_empty", 32'(empty), 32'd1);

        // Word stalls in the middle when the queue fills
        do_reset();
        fill(510, 0);
        chk("st_count510", 32'(count), 32'd510);
        push_valid = 1'b1;
        push_len   = 3'd4;
        push_data  = 32'hDEAD_BEEF;
        tick();
        push_valid = 1'b0;
        tick();
        chk("st_full", 32'(full), 32'd1);
        chk("st_push_ready", 32'(push_ready), 32'd0);
        tick();
        chk("st_stalled_count", 32'(count), 32'd512);
        for (int i = 0; i < 510; i++) exp_q.push_back(8'(i));
        exp_q.push_back(8'hDE);
        exp_q.push_back(8'hAD);
        exp_q.push_back(8'hBE);
        exp_q.push_back(8'hEF);
        drain(1, "st_pop1");
        chk("st_after_pop1", 32'(count), 32'd511);
        tick();
        chk("st_refill1", 32'(count), 32'd512);
        drain(1, "st_pop2");
        chk("st_after_pop2", 32'(count), 32'd511);
        tick();
        chk("st_refill2", 32'(count), 32'd512);
        chk("st_idle_full_ready", 32'(push_ready), 32'd0);
        tick();
        chk("st_no_extra", 32'(count), 32'd512);
        drain(512, "st_order");
        chk("st_empty", 32'(empty), 32'd1);

        // Zero-length push is a no-op; oversize length clamps to a full word
        do_reset();
        push_valid = 1'b1;
        push_len   = 3'd0;
        push_data  = 32'h1122_3344;
        tick();
        push_valid = 1'b0;
        chk("l0_count", 32'(count), 32'd0);
        chk("l0_tx_valid", 32'(tx_valid), 32'd0);
        chk("l0_push_ready", 32'(push_ready), 32'd1);
        push_valid = 1'b1;
        push_len   = 3'd7;
        tick();
        push_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("l7_count", 32'(count), 32'd4);
        chk("l7_push_ready", 32'(push_ready), 32'd1);
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        exp_q.push_back(8'h33);
        exp_q.push_back(8'h44);
        drain(4, "l7");
        chk("l7_empty", 32'(empty), 32'd1);

        // Asynchronous reset in the middle of a word
        do_reset();
        push_valid = 1'b1;
        push_len   = 3'd4;
        push_data  = 32'hCAFE_F00D;
        tick();
        push_valid = 1'b0;
        tick();
        chk("ar_pre_count", 32'(count), 32'd2);
        #2;
        INITIALIZE = 1'b1;
        #1;
        chk("ar_push_ready", 32'(push_ready), 32'd1);
        chk("ar_tx_valid", 32'(tx_valid), 32'd0);
        chk("ar_count", 32'(count), 32'd0);
        chk("ar_empty", 32'(empty), 32'd1);
        chk("ar_full", 32'(full), 32'd0);
        #1;
        INITIALIZE = 1'b0;
        tick();
        tick();
        tick();
        chk("ar_post_count", 32'(count), 32'd0);
        chk("ar_post_tx_valid", 32'(tx_valid), 32'd0);

`ifdef TXQ_DROP_ON_FULL_EN
        // Drop-on-full: producer never stalls, bytes discarded, overflow sticky
        do_reset();
        fill(512, 0);
        chk("dr_full", 32'(full), 32'd1);
        chk("dr_ready_full", 32'(push_ready), 32'd1);
        push_valid = 1'b1;
        push_len   = 3'd2;
        push_data  = 32'h0000_AABB;
        tick();
        push_valid = 1'b0;
        tick();
        chk("dr_overflow", 32'(overflow), 32'd1);
        chk("dr_count", 32'(count), 32'd512);
        chk("dr_ready_after", 32'(push_ready), 32'd1);
        for (int i = 0; i < 512; i++) exp_q.push_back(8'(i));
        drain(512, "dr_order");
        chk("dr_overflow_sticky", 32'(overflow), 32'd1);
        do_reset();
        chk("dr_overflow_clear", 32'(overflow), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tx_byte_queue.md
# tx_byte_queue

Parametrised output byte queue between the core's print instructions and the UART transmitter. The core pushes 1 to WORD_BYTES bytes per request: a single char, or a full integer/float word sent most-significant byte first. The block serialises them into a circular byte buffer and presents them one per cycle on a valid/ready stream to the transmitter. It supersedes the fixed 512-entry single-byte send queue. It adds multi-byte words, exact full/empty tracking (all DEPTH entries usable) and optional drop-on-full.

## Interface
Parameters:
- DEPTH, 512, buffer entries in bytes; power of two, ≥ 2·WORD_BYTES
- WORD_BYTES, 4, maximum bytes per push; power of two, 1..8
- LOG_DEPTH, $clog2(DEPTH), derived; not overridden

Ports:
- CLK  in  1  clock; all state changes on rising edge
- INITIALIZE  in  1  reset, asynchronous, active-high
- push_valid  in  1  push request
- push_ready  out  1  push accepted on an edge where valid && ready
- push_data  in  8·WORD_BYTES  payload; the valid bytes are the low push_len bytes
- push_len  in  $clog2(WORD_BYTES+1)  number of bytes; 0 = no-op; values > WORD_BYTES are clamped
- tx_valid  out  1  tx_data is valid
- tx_ready  in  1  transmitter consumes the byte on an edge where valid && ready
- tx_data  out  8  head byte
- count  out  LOG_DEPTH+1  bytes currently held, 0..DEPTH
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- overflow  out  1  sticky drop flag; tied 0 unless TXQ_DROP_ON_FULL_EN is defined

## Operation
- Storage: DEPTH×8 array; wr_ptr and rd_ptr are LOG_DEPTH bits and wrap modulo DEPTH; count is held separately.
- Byte order: for length L, the bytes written are push_data[8L-1:8L-8] first, down to push_data[7:0] last.
- FSM IDLE:
  - push_ready = !full.
  - On accept with L ≥ 1: write the first byte at the accept edge.
  - Latch the remaining L-1 bytes in a staging register with a remaining counter.
  - Go to WRITE if L > 1, else stay in IDLE.
  - L == 0: accepted, nothing written, stay in IDLE.
- FSM WRITE:
  - push_ready = 0.
  - Each cycle with !full: write the next staged byte and decrement remaining.
  - Return to IDLE on the edge that writes the last byte.
  - When full: stall; no write, staged byte kept.
- Pop: tx_valid = !empty; tx_data = array[rd_ptr] (combinational read). On tx_valid && tx_ready, rd_ptr++ and count--.
- Simultaneous write and pop on one edge: count unchanged. While full, a pop frees the slot on that edge; the stalled write proceeds on the next cycle.
- Bytes are never reordered or duplicated; words are never interleaved.
- INITIALIZE asserted (any time, including mid-word): pointers, count, remaining and overflow cleared; FSM to IDLE; staged bytes discarded; array contents not cleared.
- Reset values: push_ready=1, tx_valid=0, count=0, empty=1, full=0, overflow=0. tx_data is don't-care while tx_valid=0.

## Timing
- Push-to-visible: the byte written at edge N gives tx_valid=1 in the cycle after edge N.
- Word of L bytes with no full stall: occupies edges N..N+L-1; next accept is possible at edge N+L.
- 1-byte pushes: one accepted per cycle, sustained.
- Pop throughput: 1 byte/cycle. Pop is independent of the push side.
- count, empty and full are registered and reflect all writes and pops up to the last edge.

## Configuration
- TXQ_DROP_ON_FULL_EN defined:
  - push_ready is 1 whenever in IDLE.
  - Any byte that would be written while full is discarded: the FSM advances as if written, and overflow is set sticky until INITIALIZE.
  - The producer never stalls.
- Not defined:
  - Stall semantics as in Operation; no byte is ever lost.
  - overflow is constant 0.

## Test plan
- Reset, then push L=4, data 0x41424344, tx_ready=1 → tx_data sequence 0x41,0x42,0x43,0x44 on consecutive cycles; first tx_valid the cycle after accept; count returns to 0; empty=1.
- 600 back-to-back L=1 pushes of byte i, tx_ready=0 → exactly 512 accepted, full=1, push_ready=0. Then tx_ready=1 → bytes 0..511 drained in order, then remaining pushes resume.
- Fill to 510, push L=4, data 0xDEADBEEF, tx_ready=0 → 0xDE,0xAD written, full, FSM stalls in WRITE. Pop one → 0xBE written next cycle; pop one more → 0xEF written; order preserved.
- Push L=0 and L=7 (WORD_BYTES=4), data 0x11223344 → L=0 writes nothing; L=7 writes 0x11,0x22,0x33,0x44.
- Assert INITIALIZE asynchronously mid-WRITE of an L=4 word → outputs take reset values immediately; no remaining staged byte appears after release.
- With TXQ_DROP_ON_FULL_EN defined: full queue, push L=2 → push_ready stays 1, both bytes dropped, overflow=1 until INITIALIZE, count stays 512.
